// File: rtl/cordic_pow_frontend.sv
// rtl/cordic_pow_frontend.sv - operand front end for a log/exp CORDIC power unit
//
// Accepts one IEEE-754 single-precision operand. It then does one of two things:
//   - Special operands (zero/denormal, infinity, NaN) are answered directly on
//     the bypass port, and the core is never started.
//   - Normal operands are turned into hyperbolic-vectoring inputs
//     (M+1, M-1, unbiased exponent). A start pulse goes to the core, and the
//     block waits for core_done, with a timeout.
//
// Ports:
//   clk, reset      clock; asynchronous active-low reset
//   in_valid/ready  operand handshake, in_data = IEEE-754 operand
//   core_start      one-cycle start pulse to the CORDIC core
//   core_x/core_y   Q3.27 M+1.0 / M-1.0
//   core_exp        unbiased exponent E-127
//   core_sign       result sign (operand sign AND odd exponent N)
//   core_done       core finished (honoured only while waiting)
//   byp_valid/ready special-case result handshake, byp_data = result
//   err             one-cycle pulse when the core times out
module cordic_pow_frontend #(
    parameter logic [7:0] N       = 8'd3,
    parameter logic [5:0] TIMEOUT = 6'd40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        core_start,
    output logic [29:0] core_x,
    output logic [29:0] core_y,
    output logic [7:0]  core_exp,
    output logic        core_sign,
    input  logic        core_done,
    output logic        byp_valid,
    input  logic        byp_ready,
    output logic [31:0] byp_data,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_BYPASS
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [5:0]  r_cnt;
    logic        r_err;
    logic [29:0] r_core_x;
    logic [29:0] r_core_y;
    logic [7:0]  r_core_exp;
    logic        r_core_sign;
    logic [31:0] r_byp_data;

    logic        w_accept;
    logic        w_special;
    logic        w_timeout;
    logic        w_sign;
    logic [7:0]  w_e;
    logic [22:0] w_f;
    logic [29:0] w_mant;
    logic [31:0] w_byp_res;

    assign w_e       = in_data[30:23];
    assign w_f       = in_data[22:0];
    assign w_sign    = in_data[31] & N[0];
    assign w_accept  = in_valid && (r_state == S_IDLE);
    assign w_special = (w_e == 8'h00) || (w_e == 8'hFF);
    // Restore the hidden leading one: 1.F in Q3.27.
    assign w_mant    = {3'b001, w_f, 4'b0000};
    assign w_timeout = (r_cnt == TIMEOUT - 6'd1);

    // Denormals are flushed to a signed zero. NaNs collapse to the canonical quiet NaN.
    always_comb begin
        w_byp_res = {w_sign, 31'h0};
        if (w_e == 8'hFF) begin
            w_byp_res = (w_f == 23'h0) ? {w_sign, 8'hFF, 23'h0} : 32'h7FC00000;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = w_special ? S_BYPASS : S_ISSUE;
            S_ISSUE:  w_next = S_WAIT;
            S_WAIT:   if (core_done || w_timeout) w_next = S_IDLE;
            S_BYPASS: if (byp_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 6'd0;
            r_err       <= 1'b0;
            r_core_x    <= 30'h0;
            r_core_y    <= 30'h0;
            r_core_exp  <= 8'h0;
            r_core_sign <= 1'b0;
            r_byp_data  <= 32'h0;
        end else begin
            r_state <= w_next;
            // Counter runs only inside WAIT, so it is zero on every WAIT entry.
            r_cnt   <= (r_state == S_WAIT) ? r_cnt + 6'd1 : 6'd0;
            // A done on the timeout cycle takes priority, so no error is raised.
            r_err   <= (r_state == S_WAIT) && w_timeout && !core_done;
            if (w_accept) begin
                r_core_x    <= w_mant + 30'h08000000;
                r_core_y    <= w_mant - 30'h08000000;
                r_core_exp  <= w_e - 8'd127;
                r_core_sign <= w_sign;
                if (w_special) begin
                    r_byp_data <= w_byp_res;
                end
            end
        end
    end

    assign in_ready   = (r_state == S_IDLE);
    assign core_start = (r_state == S_ISSUE);
    assign byp_valid  = (r_state == S_BYPASS);
    assign err        = r_err;
    assign core_x     = r_core_x;
    assign core_y     = r_core_y;
    assign core_exp   = r_core_exp;
    assign core_sign  = r_core_sign;
    assign byp_data   = r_byp_data;

endmodule

// File: tb/tb_cordic_pow_frontend.sv
// tb/tb_cordic_pow_frontend.sv - self-checking bench for cordic_pow_frontend
module tb_cordic_pow_frontend;
    localparam int TMO = 40;
    localparam int N1  = 3;
    localparam int N2  = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_data;
    logic        core_done;
    logic        byp_ready;

    logic        in_ready, core_start, core_sign, byp_valid, err;
    logic [29:0] core_x, core_y;
    logic [7:0]  core_exp;
    logic [31:0] byp_data;

    logic        d2_in_ready, d2_core_start, d2_core_sign, d2_byp_valid, d2_err;
    logic [29:0] d2_core_x, d2_core_y;
    logic [7:0]  d2_core_exp;
    logic [31:0] d2_byp_data;

    always #5 clk = ~clk;

    cordic_pow_frontend #(.N(8'(N1)), .TIMEOUT(6'(TMO))) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .core_start(core_start), .core_x(core_x), .core_y(core_y), .core_exp(core_exp),
        .core_sign(core_sign), .core_done(core_done), .byp_valid(byp_valid),
        .byp_ready(byp_ready), .byp_data(byp_data), .err(err)
    );

    cordic_pow_frontend #(.N(8'(N2)), .TIMEOUT(6'(TMO))) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(d2_in_ready), .in_data(in_data),
        .core_start(d2_core_start), .core_x(d2_core_x), .core_y(d2_core_y), .core_exp(d2_core_exp),
        .core_sign(d2_core_sign), .core_done(core_done), .byp_valid(d2_byp_valid),
        .byp_ready(byp_ready), .byp_data(d2_byp_data), .err(d2_err)
    );

    int checks = 0;
    int errors = 0;

    // Expected outputs for the current cycle, maintained by the stimulus.
    bit          model_on = 1'b0;
    logic        e_in_ready, e_start, e_byp_valid, e_err;
    logic        e_fmt_valid;
    logic [29:0] e_x, e_y;
    logic [7:0]  e_exp;
    logic        e_sign, e_sign2;
    logic [31:0] e_byp;

    // Observed activity, compared against literals by the main sequence.
    int          n_start = 0;
    int          n_err   = 0;
    logic [31:0] last_byp = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp_v);
        end
    endtask

    // Operand formatting from the numeric definition: M = 1.F scaled by 2^27.
    function automatic void model_format(input logic [31:0] d);
        longint one, m, wrap;
        one  = longint'(1) << 27;
        wrap = longint'(1) << 30;
        m    = one + longint'(d[22:0]) * 16;
        e_x     = 30'((m + one) % wrap);
        e_y     = 30'((m - one + wrap) % wrap);
        e_exp   = 8'((int'(d[30:23]) - 127 + 256) % 256);
        e_sign  = d[31] && ((N1 % 2) == 1);
        e_sign2 = d[31] && ((N2 % 2) == 1);
    endfunction

    function automatic logic [31:0] model_special(input logic [31:0] d, output bit sp);
        logic s;
        s  = d[31] && ((N1 % 2) == 1);
        sp = 1'b0;
        model_special = 32'h0;
        if (d[30:23] == 8'd0) begin
            sp = 1'b1;
            model_special = {s, 31'h0};
        end else if (d[30:23] == 8'd255) begin
            sp = 1'b1;
            model_special = (d[22:0] == 23'd0) ? {s, 8'hFF, 23'h0} : 32'h7FC00000;
        end
    endfunction

    always @(negedge clk) begin
        if (model_on) begin
            chk("in_ready", in_ready, e_in_ready);
            chk("core_start", core_start, e_start);
            chk("byp_valid", byp_valid, e_byp_valid);
            chk("err", err, e_err);
            if (e_byp_valid) chk("byp_data", byp_data, e_byp);
            if (e_fmt_valid) begin
                chk("core_x", core_x, e_x);
                chk("core_y", core_y, e_y);
                chk("core_exp", core_exp, e_exp);
                chk("core_sign", core_sign, e_sign);
                chk("core_sign_n2", d2_core_sign, e_sign2);
            end
        end
        if (core_start) n_start++;
        if (err) n_err++;
        if (byp_valid) last_byp = byp_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        e_err = 1'b0;
    endtask

    task automatic set_idle_after_reset();
        e_in_ready = 1'b1; e_start = 1'b0; e_byp_valid = 1'b0; e_err = 1'b0;
        e_fmt_valid = 1'b1; e_x = 30'h0; e_y = 30'h0; e_exp = 8'h0;
        e_sign = 1'b0; e_sign2 = 1'b0; e_byp = 32'h0;
    endtask

    // Present one operand in the current IDLE cycle, then run it to completion.
    // done_at: WAIT cycle (1-based) that sees core_done, 0 = never.
    // noise: keep in_valid and core_done high where they must be ignored.
    task automatic run_op(input logic [31:0] d, input int done_at, input int byp_wait, input bit noise);
        logic [31:0] res;
        bit sp;
        res = model_special(d, sp);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid   = noise;
        in_data    = noise ? 32'h3F800000 : 32'h0;
        e_in_ready = 1'b0;
        if (sp) begin
            e_byp_valid = 1'b1;
            e_byp       = res;
            e_fmt_valid = 1'b0;
            byp_ready   = 1'b0;
            for (int i = 0; i < byp_wait; i++) tick();
            byp_ready = 1'b1;
            tick();
            byp_ready   = 1'b0;
            e_byp_valid = 1'b0;
        end else begin
            model_format(d);
            e_fmt_valid = 1'b1;
            e_start     = 1'b1;
            core_done   = noise;
            tick();
            e_start   = 1'b0;
            core_done = 1'b0;
            for (int w = 1; w <= TMO; w++) begin
                core_done = (w == done_at);
                tick();
                core_done = 1'b0;
                if (w == done_at || w == TMO) begin
                    e_err = (w != done_at);
                    break;
                end
            end
        end
        e_in_ready = 1'b1;
        in_valid   = 1'b0;
    endtask

    initial begin
        int n0;
        reset = 1'b1; in_valid = 1'b0; in_data = 32'h0; core_done = 1'b0; byp_ready = 1'b0;
        set_idle_after_reset();
        #1 reset = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_core_start", core_start, 1'b0);
        chk("rst_byp_valid", byp_valid, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_core_x", core_x, 30'h0);
        chk("rst_core_y", core_y, 30'h0);
        chk("rst_core_exp", core_exp, 8'h0);
        chk("rst_byp_data", byp_data, 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        model_on = 1'b1;
        tick();

        run_op(32'h40400000, 5, 0, 1'b0);
        chk("lit_3_x", core_x, 30'h14000000);
        chk("lit_3_y", core_y, 30'h04000000);
        chk("lit_3_exp", core_exp, 8'h01);
        chk("lit_3_sign", core_sign, 1'b0);
        chk("lit_3_starts", n_start, 1);

        run_op(32'hC0400000, 3, 0, 1'b1);
        chk("lit_m3_x", core_x, 30'h14000000);
        chk("lit_m3_sign_n3", core_sign, 1'b1);
        chk("lit_m3_sign_n2", d2_core_sign, 1'b0);
        chk("lit_m3_starts", n_start, 2);

        run_op(32'h40000000, 25, 0, 1'b0);
        chk("lit_2_x", core_x, 30'h10000000);
        chk("lit_2_y", core_y, 30'h0);
        chk("lit_2_exp", core_exp, 8'h01);
        chk("lit_2_ready", in_ready, 1'b1);

        // Back-to-back accepts straight from the IDLE cycle after completion.
        run_op(32'h3E200000, 1, 0, 1'b0);
        chk("lit_0p15625_x", core_x, 30'h12000000);
        chk("lit_0p15625_exp", core_exp, 8'hFD);
        run_op(32'h7F7FFFFF, 2, 0, 1'b1);
        chk("lit_max_y", core_y, 30'h07FFFFF0);
        run_op(32'hBF000000, 7, 0, 1'b0);

        // core_done while idle must be ignored.
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        tick();

        n0 = n_start;
        last_byp = 32'hDEADBEEF;
        run_op(32'h00000000, 0, 1, 1'b0);
        chk("lit_byp_zero", last_byp, 32'h00000000);
        run_op(32'hFF800000, 0, 3, 1'b1);
        chk("lit_byp_ninf", last_byp, 32'hFF800000);
        run_op(32'h7FC00001, 0, 0, 1'b0);
        chk("lit_byp_nan", last_byp, 32'h7FC00000);
        run_op(32'h80000005, 0, 2, 1'b0);
        chk("lit_byp_denorm", last_byp, 32'h80000000);
        run_op(32'h7F800000, 0, 0, 1'b0);
        chk("lit_byp_pinf", last_byp, 32'h7F800000);
        chk("lit_byp_no_start", n_start, n0);

        n0 = n_err;
        run_op(32'h40400000, 0, 0, 1'b0);
        tick();
        chk("lit_timeout_err_once", n_err, n0 + 1);
        run_op(32'h40400000, TMO, 0, 1'b0);
        tick();
        chk("lit_done_wins", n_err, n0 + 1);
        run_op(32'h40400000, TMO - 1, 0, 1'b0);
        tick();

        // Reset 10 cycles into WAIT: everything returns to reset values at once.
        n0 = n_err;
        in_valid = 1'b1; in_data = 32'h40000000;
        tick();
        in_valid = 1'b0; e_in_ready = 1'b0; e_start = 1'b1; model_format(32'h40000000);
        tick();
        e_start = 1'b0;
        repeat (10) tick();
        model_on = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("arst_wait_in_ready", in_ready, 1'b1);
        chk("arst_wait_core_start", core_start, 1'b0);
        chk("arst_wait_core_x", core_x, 30'h0);
        chk("arst_wait_core_y", core_y, 30'h0);
        chk("arst_wait_core_exp", core_exp, 8'h0);
        chk("arst_wait_err", err, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;
        set_idle_after_reset();
        model_on = 1'b1;
        repeat (TMO + 2) tick();
        chk("arst_wait_no_err", n_err, n0);

        // Reset during BYPASS drops the result.
        in_valid = 1'b1; in_data = 32'hFF800000;
        tick();
        in_valid = 1'b0; e_in_ready = 1'b0; e_byp_valid = 1'b1; e_byp = 32'hFF800000; e_fmt_valid = 1'b0;
        tick();
        model_on = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("arst_byp_valid", byp_valid, 1'b0);
        chk("arst_byp_data", byp_data, 32'h0);
        chk("arst_byp_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1 reset = 1'b1;
        set_idle_after_reset();
        model_on = 1'b1;
        tick();
        run_op(32'h40400000, 4, 0, 1'b0);
        chk("lit_recover_x", core_x, 30'h14000000);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
